demux_frame_collector: RTL and testbench

- Sequential front-end for the 1x4 demux path.
- Accepts a serial stream of WIDTH-bit beats over a valid/ready handshake and steers each accepted beat to lane 0,1,2,3 in turn. It exposes the live 2-bit lane select (s) and enable, as a 1x4 demux would be driven.
- Captures the four lanes into holding registers and presents a completed 4-lane frame downstream over a second valid/ready handshake.

---
 rtl/demux_frame_collector_if.sv | 24 ++
 rtl/demux_frame_collector.sv | 80 ++++++++
 tb/tb_demux_frame_collector.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_frame_collector_if.sv
// Stream interface for the frame collector: serial beat input and
// 4-lane frame output, each with its own valid/ready handshake.
interface demux_frame_collector_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    // Collector side: consumes beats, produces frames
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    // Environment side: produces beats, consumes frames
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_frame_collector.sv
// Serial-to-4-lane frame collector: steers accepted beats to lanes 0..3
// in turn (exposing the 1x4 demux select/enable) and hands each completed
// frame downstream over a valid/ready handshake.
module demux_frame_collector #(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    demux_frame_collector_if.slave   bus,
    output logic [1:0]               s,
    output logic                     demux_en,
    output logic [3:0]               lane_mask
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q;
    logic [1:0]             s_q;
    logic [1:0]             s_d;
    logic [3:0]             mask_q;
    logic [2:0][WIDTH-1:0]  lanes_q;   // lane 3 goes straight into out_data
    logic [4*WIDTH-1:0]     out_data_q;
    logic                   out_valid_q;
    logic                   in_ready;
    logic                   accept;
    logic                   retire;

    // In FULL a beat may only enter if the held frame leaves the same cycle;
    // flush blocks acceptance so a dropped partial frame cannot be refilled.
    assign in_ready = rst_n && en && !flush && ((state_q == FILL) || bus.out_ready);
    assign accept   = in_ready && bus.in_valid;
    assign retire   = en && (state_q == FULL) && bus.out_ready;
    assign s_d      = s_q + 2'd1;

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign s             = s_q;
    assign lane_mask     = mask_q;
    assign demux_en      = accept;

    // Collection FSM: lane capture, frame hand-off and flush; en=0 freezes all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            s_q         <= 2'd0;
            mask_q      <= 4'd0;
            lanes_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            if (retire) begin
                out_valid_q <= 1'b0;
                state_q     <= FILL;
            end
            if (flush) begin
                s_q    <= 2'd0;
                mask_q <= 4'd0;
            end else if (accept) begin
                s_q <= s_d;
                if (s_q == 2'd3) begin
                    out_data_q  <= {bus.in_data, lanes_q[2], lanes_q[1], lanes_q[0]};
                    out_valid_q <= 1'b1;
                    mask_q      <= 4'd0;
                    state_q     <= FULL;
                end else begin
                    // s is 0 whenever a frame is held, so a same-cycle
                    // retire+accept naturally restarts at lane 0
                    mask_q[s_q] <= 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        if (s_q == 2'(k)) lanes_q[k] <= bus.in_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_frame_collector.sv
// Self-checking bench for demux_frame_collector (WIDTH=1): directed vector
// table, streaming and async-reset sequences, then randomized traffic
// against a queue-based frame model.
module tb_demux_frame_collector;
    localparam int WIDTH = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [1:0] s;
    logic       demux_en;
    logic [3:0] lane_mask;

    int n_tests = 0;
    int n_fail  = 0;

    demux_frame_collector_if #(.WIDTH(WIDTH)) bus ();

    demux_frame_collector #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .bus       (bus.slave),
        .s         (s),
        .demux_en  (demux_en),
        .lane_mask (lane_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, flush, iv, id, ordy;   // inputs
        logic [1:0] e_s;                       // expected before the edge
        logic [3:0] e_mask;
        logic       e_ov;
        logic [3:0] e_od;
        logic       e_rdy, e_dmx;
    } vec_t;

    task automatic check(input string name, input logic [1:0] a_s, input logic [3:0] a_m,
                         input logic a_ov, input logic [3:0] a_od, input logic a_r, input logic a_d,
                         input logic [1:0] e_s, input logic [3:0] e_m, input logic e_ov,
                         input logic [3:0] e_od, input logic e_r, input logic e_d);
        n_tests++;
        if ({a_s, a_m, a_ov, a_od, a_r, a_d} !== {e_s, e_m, e_ov, e_od, e_r, e_d}) begin
            n_fail++;
            $display("FAIL %s: got s=%0d mask=%b ov=%b od=%b rdy=%b dmx=%b, want s=%0d mask=%b ov=%b od=%b rdy=%b dmx=%b",
                     name, a_s, a_m, a_ov, a_od, a_r, a_d, e_s, e_m, e_ov, e_od, e_r, e_d);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic iv, input logic id, input logic ordy);
        en = e; flush = f; bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: a queue of beats of the frame being filled and one held frame
    logic q_part[$];
    logic m_hold_v;
    logic [3:0] m_hold_d;

    function automatic logic m_ready(input logic e, input logic f, input logic ordy);
        return e && !f && (!m_hold_v || ordy);
    endfunction

    function automatic logic [3:0] m_mask();
        return 4'((1 << q_part.size()) - 1);
    endfunction

    task automatic m_step(input logic e, input logic f, input logic iv, input logic id, input logic ordy);
        logic rdy;
        rdy = m_ready(e, f, ordy);
        if (e) begin
            if (m_hold_v && ordy) m_hold_v = 1'b0;
            if (f) q_part.delete();
            else if (iv && rdy) begin
                q_part.push_back(id);
                if (q_part.size() == 4) begin
                    m_hold_d = {q_part[3], q_part[2], q_part[1], q_part[0]};
                    m_hold_v = 1'b1;
                    q_part.delete();
                end
            end
        end
    endtask

    vec_t vt[$];

    initial begin
        logic [11:0] sd;
        logic        e, f, iv, id, ordy, rdy;
        bit          ok;
        int          waited;

        // en, flush, iv, id, ordy | s, mask, ov, od, rdy, dmx
        vt.push_back('{1,0,1,1,1, 0,4'b0000,0,4'b0000,1,1});  // beats 1,0,1,1
        vt.push_back('{1,0,1,0,1, 1,4'b0001,0,4'b0000,1,1});
        vt.push_back('{1,0,1,1,1, 2,4'b0011,0,4'b0000,1,1});
        vt.push_back('{1,0,1,1,1, 3,4'b0111,0,4'b0000,1,1});
        vt.push_back('{1,0,0,0,0, 0,4'b0000,1,4'b1101,0,0});  // frame A held
        vt.push_back('{1,0,1,0,0, 0,4'b0000,1,4'b1101,0,0});  // back-pressure
        vt.push_back('{1,0,1,0,1, 0,4'b0000,1,4'b1101,1,1});  // retire + accept
        vt.push_back('{1,0,1,1,1, 1,4'b0001,0,4'b1101,1,1});
        vt.push_back('{1,0,0,0,1, 2,4'b0011,0,4'b1101,1,0});
        vt.push_back('{1,1,1,1,1, 2,4'b0011,0,4'b1101,0,0});  // flush
        vt.push_back('{1,0,1,1,1, 0,4'b0000,0,4'b1101,1,1});  // clean frame
        vt.push_back('{1,0,1,0,1, 1,4'b0001,0,4'b1101,1,1});
        vt.push_back('{0,0,1,1,1, 2,4'b0011,0,4'b1101,0,0});  // en=0 x3
        vt.push_back('{0,0,1,1,1, 2,4'b0011,0,4'b1101,0,0});
        vt.push_back('{0,0,1,1,1, 2,4'b0011,0,4'b1101,0,0});
        vt.push_back('{1,0,1,1,1, 2,4'b0011,0,4'b1101,1,1});
        vt.push_back('{1,0,1,0,1, 3,4'b0111,0,4'b1101,1,1});
        vt.push_back('{1,0,0,0,1, 0,4'b0000,1,4'b0101,1,0});
        vt.push_back('{1,0,0,0,1, 0,4'b0000,0,4'b0101,1,0});

        // Reset state, with en=1 and out_ready=1: in_ready must still be 0
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        #3;
        check("reset", s, lane_mask, bus.out_valid, bus.out_data, bus.in_ready, demux_en,
              2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].flush, vt[i].iv, vt[i].id, vt[i].ordy);
            #1;
            check($sformatf("vec%0d", i), s, lane_mask, bus.out_valid, bus.out_data, bus.in_ready, demux_en,
                  vt[i].e_s, vt[i].e_mask, vt[i].e_ov, vt[i].e_od, vt[i].e_rdy, vt[i].e_dmx);
            @(negedge clk);
        end

        // Streaming: 3 frames, in_valid and out_ready tied high, no bubbles
        sd = 12'($urandom);
        for (int i = 0; i <= 12; i++) begin
            logic [3:0] fr;
            logic       ov_e;
            drive(1'b1, 1'b0, (i < 12), (i < 12) ? sd[i] : 1'b0, 1'b1);
            #1;
            ov_e = (i > 0) && (i % 4 == 0);
            fr   = ov_e ? sd[(i-4) +: 4] : bus.out_data;
            check($sformatf("stream%0d", i), s, lane_mask, bus.out_valid, bus.out_data, bus.in_ready, demux_en,
                  2'(i % 4), 4'((1 << (i % 4)) - 1), ov_e, fr, 1'b1, (i < 12));
            @(negedge clk);
        end

        // Async reset while a frame is held, between clock edges
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        waited = 0;
        while (!bus.out_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_tests++;
        if (!bus.out_valid) begin
            n_fail++;
            $display("FAIL fill_timeout: out_valid=%b after %0d cycles, want 1", bus.out_valid, waited);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ok = (clk == 1'b1);   // still in the high phase: no edge has occurred
        check("async_reset", s, lane_mask, bus.out_valid, bus.out_data, bus.in_ready, demux_en,
              2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        if (!ok) $display("note: async reset check landed after a clock edge");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the queue model
        q_part.delete();
        m_hold_v = 1'b0;
        m_hold_d = 4'd0;
        for (int c = 0; c < 3000; c++) begin
            e    = ($urandom_range(0, 9) != 0);
            f    = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            id   = 1'($urandom);
            ordy = ($urandom_range(0, 9) < 6);
            drive(e, f, iv, id, ordy);
            #1;
            rdy = m_ready(e, f, ordy);
            check($sformatf("rand%0d", c), s, lane_mask, bus.out_valid, bus.out_data, bus.in_ready, demux_en,
                  2'(q_part.size()), m_mask(), m_hold_v, m_hold_d, rdy, rdy && iv);
            m_step(e, f, iv, id, ordy);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
